// File: rtl/k005292_sync_receiver_if.sv
// Sync-receiver signal bundle: composite sync in, recovered raster position out.
interface k005292_sync_receiver_if;
  logic       i_CSYNC_n;
  logic       i_HBLANK_n;
  logic [8:0] o_HCOUNT;
  logic [8:0] o_VCOUNT;
  logic       o_HBLANK_n;
  logic       o_VSYNC_n;
  logic       o_LOCKED;
  logic       o_VSYNC_DET;
  logic [8:0] o_FRAME_LINES;
  logic       o_BLANK_ERR;

  // Video source side (timing generator / stimulus)
  modport master (
    output i_CSYNC_n, i_HBLANK_n,
    input  o_HCOUNT, o_VCOUNT, o_HBLANK_n, o_VSYNC_n, o_LOCKED,
           o_VSYNC_DET, o_FRAME_LINES, o_BLANK_ERR
  );

  // Receiver side
  modport slave (
    input  i_CSYNC_n, i_HBLANK_n,
    output o_HCOUNT, o_VCOUNT, o_HBLANK_n, o_VSYNC_n, o_LOCKED,
           o_VSYNC_DET, o_FRAME_LINES, o_BLANK_ERR
  );
endinterface

// File: rtl/k005292_sync_receiver.sv
// Composite-sync receiver: classifies CSYNC low pulses, runs a flywheel H/V
// counter aligned to the transmitter and qualifies lock with SEARCH/ACQUIRE/LOCKED.
module k005292_sync_receiver (
  input  logic                     i_EMU_MCLK,
  input  logic                     i_MRST_n,
  input  logic                     i_EMU_CLK6MPCEN_n,
  k005292_sync_receiver_if.slave   bus
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [8:0]  hcnt_q, hcnt_d;
  logic [8:0]  vcnt_q, vcnt_d;
  logic [8:0]  line_q, line_d;
  logic [8:0]  frame_q, frame_d;
  logic [11:0] run_q, run_d;
  logic [3:0]  good_q, good_d;
  logic [2:0]  miss_q, miss_d;
  logic        prev_q, prev_d;
  logic        vdet_q, vdet_d;
  logic        berr_q, berr_d;

  logic        ce;
  logic        rise;
  logic        hs_edge;
  logic        vs_edge;
  logic        sync_edge;
  logic        match;
  logic        line_tick;
  logic [8:0]  hnext;

  assign ce        = ~i_EMU_CLK6MPCEN_n;
  // Run length is the pre-update run counter at the enable that sees CSYNC return high
  assign rise      = bus.i_CSYNC_n & ~prev_q;
  assign hs_edge   = rise && (run_q >= 12'd16)   && (run_q <= 12'd63);
  assign vs_edge   = rise && (run_q >= 12'd1024) && (run_q <= 12'd4094);
  assign sync_edge = hs_edge | vs_edge;
  assign match     = sync_edge && (hcnt_q == 9'd208);
  assign line_tick = (hcnt_q == 9'd175);
  assign hnext     = (hcnt_q == 9'd511) ? 9'd128 : hcnt_q + 9'd1;

  // Pulse measurement, vertical flywheel, frame length and blanking check
  always_comb begin
    run_d   = bus.i_CSYNC_n ? '0 : ((run_q == '1) ? run_q : run_q + 12'd1);
    prev_d  = bus.i_CSYNC_n;
    vcnt_d  = vcnt_q;
    line_d  = line_q;
    frame_d = frame_q;
    vdet_d  = 1'b0;
    berr_d  = berr_q | ((state_q == LOCKED) && (bus.i_HBLANK_n != hcnt_q[8]));
    if (line_tick) begin
      vcnt_d = (vcnt_q == 9'd511) ? 9'd248 : vcnt_q + 9'd1;
      line_d = (line_q == '1) ? line_q : line_q + 9'd1;
    end
    // A vertical sync end overrides the line tick
    if (vs_edge) begin
      vcnt_d  = 9'd256;
      line_d  = '0;
      frame_d = line_q;
      vdet_d  = 1'b1;
    end
  end

  // Lock state machine and horizontal flywheel (re)alignment
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    hcnt_d  = hnext;
    unique case (state_q)
      SEARCH: begin
        if (sync_edge) begin
          hcnt_d  = 9'd209;
          good_d  = '0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (match) begin
          good_d = good_q + 4'd1;
          if (good_q == 4'd7) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end else if (rise) begin
          good_d = '0;
          hcnt_d = 9'd209;
        end
      end
      LOCKED: begin
        if (match) begin
          miss_d = '0;
        end else if (rise) begin
          miss_d = miss_q + 3'd1;
          if (miss_q == 3'd3) state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
    // A stuck-low CSYNC means the source is gone
    if ((state_q != SEARCH) && (run_d == '1)) state_d = SEARCH;
  end

  // State register
  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
      miss_q  <= '0;
      hcnt_q  <= 9'd128;
    end else if (ce) begin
      state_q <= state_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Datapath registers
  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      run_q   <= '0;
      prev_q  <= 1'b1;
      vcnt_q  <= 9'd248;
      line_q  <= '0;
      frame_q <= '0;
      vdet_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else if (ce) begin
      run_q   <= run_d;
      prev_q  <= prev_d;
      vcnt_q  <= vcnt_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      vdet_q  <= vdet_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.o_HCOUNT      = hcnt_q;
  assign bus.o_VCOUNT      = vcnt_q;
  assign bus.o_HBLANK_n    = hcnt_q[8];
  assign bus.o_VSYNC_n     = vcnt_q[8];
  assign bus.o_LOCKED      = (state_q == LOCKED);
  assign bus.o_VSYNC_DET   = vdet_q;
  assign bus.o_FRAME_LINES = frame_q;
  assign bus.o_BLANK_ERR   = berr_q;

endmodule
